gray_code_counter: RTL and testbench

//   Parametrised, registered up/down counter that presents its count as both

---
 rtl/gray_code_counter_pkg.sv | 11 +
 rtl/gray_defs.vh | 12 +
 rtl/gray_to_binary.sv | 22 ++
 rtl/gray_code_counter.sv | 101 ++++++++++
 tb/tb_gray_code_counter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/gray_code_counter_pkg.sv
// Shared types for the Gray-code counter family.
package gray_code_counter_pkg;

  // Source selected for the next binary count (reset is handled in the register).
  typedef enum logic [1:0] {
    SEL_HOLD  = 2'd0,
    SEL_COUNT = 2'd1,
    SEL_LOAD  = 2'd2
  } next_sel_e;

endpackage

// File: rtl/gray_defs.vh
// Shared Gray-code definitions for counters and FIFO pointers.
// Include inside a module body that declares a WIDTH parameter.
`ifndef GRAY_DEFS_VH
`define GRAY_DEFS_VH
`define GRAY_DIR_UP 1'b1
`define GRAY_DIR_DN 1'b0
`endif

// Reflected Gray encoding of a WIDTH-bit binary value.
function automatic logic [WIDTH-1:0] b2g(input logic [WIDTH-1:0] b);
  return b ^ (b >> 1);
endfunction

// File: rtl/gray_to_binary.sv
// Combinational reflected-Gray to binary decoder, one XOR stage per bit.
module gray_to_binary
  import gray_code_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Prefix XOR from the MSB down.
  always_comb begin : g2b_chain
    logic [WIDTH-1:0] b_v;
    b_v = '0;
    b_v[WIDTH-1] = gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b_v[i] = b_v[i+1] ^ gray[i];
    end
    bin = b_v;
  end

endmodule

// File: rtl/gray_code_counter.sv
// Registered up/down counter presenting binary and Gray views of the same count,
// with binary or Gray load and a one-cycle wrap pulse.
module gray_code_counter
  import gray_code_counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             load_is_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap
);

  `include "gray_defs.vh"

  localparam logic [WIDTH-1:0] RESET_BIN  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] RESET_GRAY = b2g(RESET_BIN);
  localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};

  next_sel_e        sel_s;
  logic [WIDTH-1:0] load_bin_s;
  logic [WIDTH-1:0] next_bin_s;
  logic [WIDTH-1:0] next_gray_s;
  logic             wrap_next_s;
  logic [WIDTH-1:0] bin_r;
  logic [WIDTH-1:0] gray_r;
  logic             wrap_r;

  gray_to_binary #(.WIDTH(WIDTH)) u_load_g2b (
    .gray (load_val),
    .bin  (load_bin_s)
  );

  // Load outranks counting; reset is applied in the register block.
  always_comb begin
    sel_s = SEL_HOLD;
    if (load) begin
      sel_s = SEL_LOAD;
    end else if (en) begin
      sel_s = SEL_COUNT;
    end else begin
      sel_s = SEL_HOLD;
    end
  end

  // Next binary count and wrap detection from the current count.
  always_comb begin
    next_bin_s  = bin_r;
    wrap_next_s = 1'b0;
    case (sel_s)
      SEL_LOAD: begin
        next_bin_s = load_is_gray ? load_bin_s : load_val;
      end
      SEL_COUNT: begin
        if (up == `GRAY_DIR_UP) begin
          next_bin_s  = bin_r + ONE;
          wrap_next_s = (bin_r == {WIDTH{1'b1}});
        end else begin
          next_bin_s  = bin_r - ONE;
          wrap_next_s = (bin_r == {WIDTH{1'b0}});
        end
      end
      SEL_HOLD: begin
        next_bin_s = bin_r;
      end
      default: begin
        next_bin_s = bin_r;
      end
    endcase
  end

  // Gray is encoded from the next count so it never lags the binary register.
  always_comb begin
    next_gray_s = b2g(next_bin_s);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_r  <= RESET_BIN;
      gray_r <= RESET_GRAY;
      wrap_r <= 1'b0;
    end else begin
      bin_r  <= next_bin_s;
      gray_r <= next_gray_s;
      wrap_r <= wrap_next_s;
    end
  end

  assign bin  = bin_r;
  assign gray = gray_r;
  assign wrap = wrap_r;

endmodule

// File: tb/tb_gray_code_counter.sv
// Self-checking bench: directed WIDTH=4 scenarios plus randomized WIDTH=8,
// RESET_VAL=5 run against an arithmetic reference model.
module tb_gray_code_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic       a_rst, a_en, a_up, a_load, a_lig;
  logic [3:0] a_lv, a_bin, a_gray;
  logic       a_wrap;

  logic       b_rst, b_en, b_up, b_load, b_lig;
  logic [7:0] b_lv, b_bin, b_gray;
  logic       b_wrap;

  gray_code_counter #(.WIDTH(4), .RESET_VAL(0)) dut_a (
    .clk(clk), .rst(a_rst), .en(a_en), .up(a_up), .load(a_load),
    .load_is_gray(a_lig), .load_val(a_lv), .bin(a_bin), .gray(a_gray), .wrap(a_wrap)
  );

  gray_code_counter #(.WIDTH(8), .RESET_VAL(5)) dut_b (
    .clk(clk), .rst(b_rst), .en(b_en), .up(b_up), .load(b_load),
    .load_is_gray(b_lig), .load_val(b_lv), .bin(b_bin), .gray(b_gray), .wrap(b_wrap)
  );

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  // Inverse by exhaustive search over the code space.
  function automatic int from_gray(input int g, input int w);
    for (int b = 0; b < (1 << w); b++) begin
      if (to_gray(b) == g) return b;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; a_en = 1'b0; a_up = 1'b1; a_load = 1'b0; a_lig = 1'b0; a_lv = 4'd0;
    tick(); tick();
    tests++;
    if (a_bin !== 4'd0 || a_gray !== 4'd0 || a_wrap !== 1'b0) begin
      fails++;
      $display("FAIL reset: bin=%b gray=%b wrap=%b, want 0000 0000 0", a_bin, a_gray, a_wrap);
    end
    a_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (a_bin !== 4'd0 || a_gray !== 4'd0 || a_wrap !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold[%0d]: bin=%b gray=%b wrap=%b, want 0000 0000 0", i, a_bin, a_gray, a_wrap);
      end
    end
  endtask

  task automatic test_count_up();
    int exp_b;
    logic [3:0] prev_g;
    exp_b = 0;
    a_en = 1'b1; a_up = 1'b1;
    for (int i = 0; i < 16; i++) begin
      prev_g = a_gray;
      tick();
      exp_b = (exp_b + 1) % 16;
      tests++;
      if (a_bin !== 4'(exp_b) || a_gray !== 4'(to_gray(exp_b)) || a_wrap !== (exp_b == 0)) begin
        fails++;
        $display("FAIL count_up[%0d]: bin=%b gray=%b wrap=%b, want %b %b %b", i, a_bin, a_gray,
                 a_wrap, 4'(exp_b), 4'(to_gray(exp_b)), (exp_b == 0));
      end
      tests++;
      if ($countones(prev_g ^ a_gray) != 1) begin
        fails++;
        $display("FAIL count_up_step[%0d]: gray %b -> %b, want one bit change", i, prev_g, a_gray);
      end
    end
    a_en = 1'b0;
  endtask

  task automatic test_count_down();
    a_en = 1'b1; a_up = 1'b0;
    tick();
    tests++;
    if (a_bin !== 4'b1111 || a_gray !== 4'b1000 || a_wrap !== 1'b1) begin
      fails++;
      $display("FAIL down_wrap: bin=%b gray=%b wrap=%b, want 1111 1000 1", a_bin, a_gray, a_wrap);
    end
    a_en = 1'b0;
    tick();
    tests++;
    if (a_bin !== 4'b1111 || a_gray !== 4'b1000 || a_wrap !== 1'b0) begin
      fails++;
      $display("FAIL down_hold: bin=%b gray=%b wrap=%b, want 1111 1000 0", a_bin, a_gray, a_wrap);
    end
  endtask

  task automatic test_load();
    a_load = 1'b1; a_lig = 1'b0; a_lv = 4'b1010;
    tick();
    tests++;
    if (a_bin !== 4'b1010 || a_gray !== 4'b1111 || a_wrap !== 1'b0) begin
      fails++;
      $display("FAIL load_bin: bin=%b gray=%b wrap=%b, want 1010 1111 0", a_bin, a_gray, a_wrap);
    end
    a_lig = 1'b1; a_lv = 4'b0110;
    tick();
    tests++;
    if (a_bin !== 4'b0100 || a_gray !== 4'b0110 || a_wrap !== 1'b0) begin
      fails++;
      $display("FAIL load_gray: bin=%b gray=%b wrap=%b, want 0100 0110 0", a_bin, a_gray, a_wrap);
    end
    a_load = 1'b0; a_lig = 1'b0;
  endtask

  task automatic test_load_priority();
    a_load = 1'b1; a_lig = 1'b0; a_lv = 4'b1111;
    tick();
    tests++;
    if (a_bin !== 4'b1111) begin
      fails++;
      $display("FAIL preload: bin=%b, want 1111", a_bin);
    end
    // At all-ones a count-up would wrap; the load must win and suppress wrap.
    a_en = 1'b1; a_up = 1'b1; a_lv = 4'b0011;
    tick();
    tests++;
    if (a_bin !== 4'b0011 || a_gray !== 4'b0010 || a_wrap !== 1'b0) begin
      fails++;
      $display("FAIL load_over_en: bin=%b gray=%b wrap=%b, want 0011 0010 0", a_bin, a_gray, a_wrap);
    end
    a_rst = 1'b1; a_lv = 4'b1001;
    tick();
    tests++;
    if (a_bin !== 4'b0000 || a_gray !== 4'b0000 || a_wrap !== 1'b0) begin
      fails++;
      $display("FAIL rst_over_load: bin=%b gray=%b wrap=%b, want 0000 0000 0", a_bin, a_gray, a_wrap);
    end
    a_rst = 1'b0; a_load = 1'b0; a_en = 1'b0;
  endtask

  task automatic test_random();
    int m, w, prev_g;
    bit counted;
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0;
    m = 5;
    tests++;
    if (b_bin !== 8'd5 || b_gray !== 8'(to_gray(5)) || b_wrap !== 1'b0) begin
      fails++;
      $display("FAIL rand_reset: bin=%0d gray=%b wrap=%b, want 5 %b 0", b_bin, b_gray, b_wrap, 8'(to_gray(5)));
    end
    for (int c = 0; c < 1000; c++) begin
      b_rst  = ($urandom_range(0, 63) == 0);
      b_load = ($urandom_range(0, 7) == 0);
      b_lig  = 1'($urandom_range(0, 1));
      b_lv   = 8'($urandom_range(0, 255));
      b_en   = ($urandom_range(0, 3) != 0);
      // Long same-direction runs make wraps in both directions likely.
      if ($urandom_range(0, 15) == 0) b_up = ~b_up;
      prev_g = to_gray(m);
      counted = 1'b0;
      w = 0;
      if (b_rst) begin
        m = 5;
      end else if (b_load) begin
        m = b_lig ? from_gray(int'(b_lv), 8) : int'(b_lv);
      end else if (b_en) begin
        counted = 1'b1;
        if (b_up) begin
          w = (m == 255);
          m = (m + 1) % 256;
        end else begin
          w = (m == 0);
          m = (m + 255) % 256;
        end
      end
      tick();
      tests++;
      if (b_bin !== 8'(m) || b_gray !== 8'(to_gray(m)) || b_wrap !== 1'(w)) begin
        fails++;
        $display("FAIL rand[%0d]: bin=%0d gray=%b wrap=%b, want %0d %b %0d", c, b_bin, b_gray,
                 b_wrap, m, 8'(to_gray(m)), w);
      end
      tests++;
      if (b_gray !== (b_bin ^ (b_bin >> 1))) begin
        fails++;
        $display("FAIL rand_invariant[%0d]: gray=%b bin=%b", c, b_gray, b_bin);
      end
      if (counted) begin
        tests++;
        if ($countones(8'(prev_g) ^ b_gray) != 1) begin
          fails++;
          $display("FAIL rand_step[%0d]: gray %b -> %b, want one bit change", c, 8'(prev_g), b_gray);
        end
      end
    end
    b_rst = 1'b0; b_load = 1'b0; b_en = 1'b0;
  endtask

  initial begin
    b_rst = 1'b1; b_en = 1'b0; b_up = 1'b1; b_load = 1'b0; b_lig = 1'b0; b_lv = 8'd0;
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_load_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
